jtag_scan_driver: RTL and testbench
===================================

// Module: jtag_scan_driver
// PURPOSE
// Synthesizable JTAG scan master that sits directly upstream of the TDO monitor.
// - It walks the DUT TAP from Run-Test-Idle through one IR scan (instruction load) and one DR scan.
// - The DR scan shifts a BSC_SIZE-bit boundary-scan pattern out on TDI and captures the returned TDO bits.
// - Its TDI, strobe and shift_dr outputs are the stream, compare-qualifier and shift window the monitor consumes.
// PARAMETERS
// BSC_SIZE     14  boundary-scan chain length (DR scan bits)
// IR_SIZE       4  instruction register length
// RESET_CYCLES  5  TMS=1 cycles issued after reset to force Test-Logic-Reset
// PORTS
// TCK       in   1         scan clock; all state updates on posedge TCK
// RST       in   1         asynchronous, active-high reset
// start     in   1         request one IR+DR scan; sampled only when busy=0
// cmp_en    in   1         enable strobe (monitor compare) for this scan; latched with start
// instr     in   IR_SIZE   instruction; latched on accepted start
// pattern   in   BSC_SIZE  DR pattern; latched on accepted start
// TDO       in   1         serial data from DUT
// TMS       out  1         TAP mode select to DUT
// TDI       out  1         serial data to DUT and monitor
// shift_dr  out  1         high while the DUT TAP is in Shift-DR (monitor shift window)
// strobe    out  1         cmp_en_latched & shift_dr
// busy      out  1         scan in progress or reset sequence running
// done      out  1         one-cycle pulse at scan completion
// tdo_data  out  BSC_SIZE  captured TDO bits; bit i = TDO returned for DR shift i
// BEHAVIOUR
// - Registered outputs: a value driven at posedge k is sampled by the DUT at posedge k+1.
// - Reset values: TMS=1, TDI=0, shift_dr=0, strobe=0, busy=1, done=0, tdo_data=0.
// - RST deasserted -> RESET_CYCLES cycles of TMS=1, then one cycle TMS=0 (to RTI), then IDLE with busy=0.
// - IDLE: TMS=0, TDI=0. start=1 -> latch instr/pattern/cmp_en; busy=1 from the next cycle.
// - Post-start TMS sequence, one entry per TCK:
//   - IR_SEL: 1,1,0,0 = Select-DR, Select-IR, Capture-IR, Shift-IR.
//   - IR_SHIFT: IR_SIZE cycles; TDI=instr[i], LSB first; TMS=0 except TMS=1 on the last bit (Exit1-IR).
//   - IR_UPD: TMS 1,0 = Update-IR, RTI.
//   - DR_SEL: TMS 1,0,0 = Select-DR, Capture-DR, Shift-DR.
//   - DR_SHIFT: BSC_SIZE cycles; TDI=pattern[i], LSB first; TMS=1 on the last bit.
//   - DR_UPD: TMS 1,0 = Update-DR, RTI.
//   - DONE: done=1 for 1 cycle, busy=0 in the same cycle; return to IDLE.
// - Scan length: start accept to done = IR_SIZE+BSC_SIZE+11 cycles.
// - shift_dr: high exactly for the BSC_SIZE posedges at which the DUT samples a DR TDI bit.
// - tdo_data[i] is loaded from TDO at the posedge where the DUT samples pattern[i].
// - tdo_data holds its value until the next accepted start, then clears to 0.
// - One bit counter, width $clog2(max(IR_SIZE,BSC_SIZE)+1); it reloads on each shift-phase entry.
//   - The terminal count selects the TMS=1 exit bit.
// - start while busy=1 is ignored (no queueing). start and done can coincide only in IDLE+1;
//   start is accepted only in IDLE.
// - RST mid-scan: async return to reset values; the reset sequence re-runs.
//   - No done pulse is issued; the partial tdo_data is discarded.
// - IR_SIZE=1 / BSC_SIZE=1: the single shift bit carries TMS=1.
// STRUCTURE
// - jtag_pkg: scan_state_e enum (RST_SEQ, IDLE, IR_SEL, IR_SHIFT, IR_UPD, DR_SEL, DR_SHIFT, DR_UPD, DONE).
// - jtag_pkg: TAP TMS step constants; default IR codes (EXTEST=4'b0000, SAMPLE=4'b0010, BYPASS=4'b1111).
// - One natural sub-module: jtag_bit_counter (load/decrement/terminal flag) shared by IR and DR phases.
// TESTING
// 1. RST pulse, then release -> TMS=1 for exactly 5 TCKs, one TMS=0, then busy=0, TDI=0.
// 2. instr=4'b0010, pattern=14'h2A5C, cmp_en=1 -> TMS/TDI match the sequence; shift_dr/strobe high 14 cycles;
//    done at cycle 29 after start.
// 3. Loop-back TDI->TDO through a 14-bit shift register model -> tdo_data = previous pattern; for the second scan
//    with pattern=14'h1555, tdo_data=14'h2A5C.
// 4. start held high during busy -> exactly one scan; start=1 in the cycle after done -> second scan accepted.
// 5. RST asserted at DR shift bit 7 -> outputs at reset values immediately; no done; reset sequence re-runs;
//    the next scan completes normally.
// 6. cmp_en=0 scan -> shift_dr pulses 14 cycles, strobe stays 0; an SVA checks shift_dr==DUT TAP Shift-DR
//    throughout.

Source files
------------

// File: rtl/jtag_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_pkg
// Purpose  : Shared types and TAP TMS step constants for the JTAG scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    typedef enum logic [3:0] {
        RST_SEQ  = 4'd0,
        IDLE     = 4'd1,
        IR_SEL   = 4'd2,
        IR_SHIFT = 4'd3,
        IR_UPD   = 4'd4,
        DR_SEL   = 4'd5,
        DR_SHIFT = 4'd6,
        DR_UPD   = 4'd7,
        DONE     = 4'd8
    } scan_state_e;

    // TMS per step, bit n = step n: Select-DR, Select-IR, Capture-IR, Shift-IR
    localparam logic [3:0] c_ir_sel_tms = 4'b0011;
    // Select-DR, Capture-DR, Shift-DR (bit 3 unused)
    localparam logic [3:0] c_dr_sel_tms = 4'b0001;
    // Update, then Run-Test-Idle
    localparam logic [1:0] c_upd_tms    = 2'b01;

    localparam logic [3:0] c_extest = 4'b0000;
    localparam logic [3:0] c_sample = 4'b0010;
    localparam logic [3:0] c_bypass = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/jtag_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_scan_driver_if
// Purpose  : Host request / TAP pin / monitor bundle of the JTAG scan driver.
// Revision : 1.0 - initial release
// ============================================================================
interface jtag_scan_driver_if #(
    parameter int BSC_SIZE = 14,
    parameter int IR_SIZE  = 4
);
    logic                start;
    logic                cmp_en;
    logic [IR_SIZE-1:0]  instr;
    logic [BSC_SIZE-1:0] pattern;
    logic                TDO;
    logic                TMS;
    logic                TDI;
    logic                shift_dr;
    logic                strobe;
    logic                busy;
    logic                done;
    logic [BSC_SIZE-1:0] tdo_data;

    modport master (
        input  start, cmp_en, instr, pattern, TDO,
        output TMS, TDI, shift_dr, strobe, busy, done, tdo_data
    );

    modport slave (
        output start, cmp_en, instr, pattern, TDO,
        input  TMS, TDI, shift_dr, strobe, busy, done, tdo_data
    );
endinterface
`default_nettype wire

// File: rtl/jtag_scan_driver_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : jtag_bit_counter
// Purpose  : Loadable down-counter whose terminal flag marks the last shift bit.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_bit_counter #(
    parameter int WIDTH = 4
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_load,
    input  wire [WIDTH-1:0]  i_load_val,
    input  wire              i_dec,
    output logic             o_term
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_term = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/jtag_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : jtag_scan_driver
// Purpose  : JTAG scan master: TAP reset, one IR scan and one DR scan per start.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_scan_driver
    import jtag_pkg::*;
#(
    parameter int BSC_SIZE     = 14,
    parameter int IR_SIZE      = 4,
    parameter int RESET_CYCLES = 5
) (
    input  wire              TCK,
    input  wire              RST,
    jtag_scan_driver_if.master bus
);
    localparam int c_max_size = (IR_SIZE > BSC_SIZE) ? IR_SIZE : BSC_SIZE;
    localparam int c_cnt_w    = $clog2(c_max_size + 1);
    localparam int c_rst_w    = $clog2(RESET_CYCLES + 2);
    localparam logic [c_cnt_w-1:0] c_ir_last  = c_cnt_w'(IR_SIZE - 1);
    localparam logic [c_cnt_w-1:0] c_dr_last  = c_cnt_w'(BSC_SIZE - 1);
    localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(RESET_CYCLES);

    // State names the entry to be driven at the next TCK edge
    scan_state_e         r_state, w_state_nxt;
    logic [1:0]          r_step, w_step_nxt;
    logic [c_rst_w-1:0]  r_rst_cnt, w_rst_cnt_nxt;
    logic [IR_SIZE-1:0]  r_instr;
    logic [BSC_SIZE-1:0] r_pattern, r_tdo_data, w_tdo_next;
    logic                r_cmp_en;
    logic                r_tms, r_tdi, r_shift_dr, r_strobe, r_busy, r_done;
    logic                w_tms, w_tdi, w_shift_dr, w_busy, w_done;
    logic                w_accept, w_ir_shift, w_dr_shift;
    logic                w_cnt_load, w_cnt_dec, w_cnt_term;
    logic [c_cnt_w-1:0]  w_cnt_load_val;

    jtag_bit_counter #(.WIDTH(c_cnt_w)) u_bit_counter (
        .clk        (TCK),
        .rst        (RST),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_term     (w_cnt_term)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        w_rst_cnt_nxt  = r_rst_cnt;
        w_tms          = 1'b0;
        w_tdi          = 1'b0;
        w_shift_dr     = 1'b0;
        w_busy         = 1'b1;
        w_done         = 1'b0;
        w_accept       = 1'b0;
        w_ir_shift     = 1'b0;
        w_dr_shift     = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_dec      = 1'b0;
        w_cnt_load_val = c_ir_last;
        case (r_state)
            RST_SEQ: begin
                if (r_rst_cnt < c_rst_last) begin
                    w_tms         = 1'b1;
                    w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                w_busy = 1'b0;
                // r_busy still high on the first IDLE cycle after the reset walk
                if (bus.start && !r_busy) begin
                    w_accept    = 1'b1;
                    w_busy      = 1'b1;
                    w_tms       = c_ir_sel_tms[0];
                    w_step_nxt  = 2'd1;
                    w_state_nxt = IR_SEL;
                end
            end
            IR_SEL: begin
                w_tms = c_ir_sel_tms[r_step];
                if (r_step == 2'd3) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_ir_last;
                    w_state_nxt    = IR_SHIFT;
                end else begin
                    w_step_nxt = r_step + 2'd1;
                end
            end
            IR_SHIFT: begin
                w_tdi      = r_instr[0];
                w_tms      = w_cnt_term;
                w_ir_shift = 1'b1;
                w_cnt_dec  = 1'b1;
                if (w_cnt_term) begin
                    w_step_nxt  = 2'd0;
                    w_state_nxt = IR_UPD;
                end
            end
            IR_UPD: begin
                w_tms = c_upd_tms[r_step[0]];
                if (r_step[0]) begin
                    w_step_nxt  = 2'd0;
                    w_state_nxt = DR_SEL;
                end else begin
                    w_step_nxt = 2'd1;
                end
            end
            DR_SEL: begin
                w_tms = c_dr_sel_tms[r_step];
                if (r_step == 2'd2) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_dr_last;
                    w_state_nxt    = DR_SHIFT;
                end else begin
                    w_step_nxt = r_step + 2'd1;
                end
            end
            DR_SHIFT: begin
                w_tdi      = r_pattern[0];
                w_tms      = w_cnt_term;
                w_shift_dr = 1'b1;
                w_dr_shift = 1'b1;
                w_cnt_dec  = 1'b1;
                if (w_cnt_term) begin
                    w_step_nxt  = 2'd0;
                    w_state_nxt = DR_UPD;
                end
            end
            DR_UPD: begin
                w_tms = c_upd_tms[r_step[0]];
                if (r_step[0]) begin
                    w_step_nxt  = 2'd0;
                    w_state_nxt = DONE;
                end else begin
                    w_step_nxt = 2'd1;
                end
            end
            DONE: begin
                w_busy      = 1'b0;
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = RST_SEQ;
            end
        endcase
    end

    // Capture fills from the MSB so the first DR bit ends up in bit 0
    generate
        if (BSC_SIZE > 1) begin : g_tdo_wide
            assign w_tdo_next = {bus.TDO, r_tdo_data[BSC_SIZE-1:1]};
        end else begin : g_tdo_single
            assign w_tdo_next = bus.TDO;
        end
    endgenerate

    always_ff @(posedge TCK or posedge RST) begin
        if (RST) begin
            r_state    <= RST_SEQ;
            r_step     <= 2'd0;
            r_rst_cnt  <= '0;
            r_instr    <= '0;
            r_pattern  <= '0;
            r_cmp_en   <= 1'b0;
            r_tms      <= 1'b1;
            r_tdi      <= 1'b0;
            r_shift_dr <= 1'b0;
            r_strobe   <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_tdo_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_rst_cnt  <= w_rst_cnt_nxt;
            r_tms      <= w_tms;
            r_tdi      <= w_tdi;
            r_shift_dr <= w_shift_dr;
            r_strobe   <= w_shift_dr & r_cmp_en;
            r_busy     <= w_busy;
            r_done     <= w_done;
            if (w_accept) begin
                r_instr    <= bus.instr;
                r_pattern  <= bus.pattern;
                r_cmp_en   <= bus.cmp_en;
                r_tdo_data <= '0;
            end else begin
                if (w_ir_shift) r_instr <= r_instr >> 1;
                if (w_dr_shift) r_pattern <= r_pattern >> 1;
                // r_shift_dr high means the TAP samples a DR bit at this edge
                if (r_shift_dr) r_tdo_data <= w_tdo_next;
            end
        end
    end

    assign bus.TMS      = r_tms;
    assign bus.TDI      = r_tdi;
    assign bus.shift_dr = r_shift_dr;
    assign bus.strobe   = r_strobe;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.tdo_data = r_tdo_data;
endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_scan_driver
// Purpose  : Directed bench for jtag_scan_driver with a TAP and boundary-register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_scan_driver;
    import jtag_pkg::*;

    logic TCK = 1'b0;
    logic RST = 1'b0;
    always #5 TCK = ~TCK;

    jtag_scan_driver_if #(.BSC_SIZE(14), .IR_SIZE(4)) bus ();

    jtag_scan_driver #(.BSC_SIZE(14), .IR_SIZE(4), .RESET_CYCLES(5)) dut (
        .TCK (TCK),
        .RST (RST),
        .bus (bus)
    );

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    tap_e        tap;
    logic [13:0] bsr = 14'h3001;

    always @(posedge TCK or posedge RST) begin
        if (RST) tap <= TLR;
        else begin
            case (tap)
                TLR:    tap <= bus.TMS ? TLR    : RTI;
                RTI:    tap <= bus.TMS ? SEL_DR : RTI;
                SEL_DR: tap <= bus.TMS ? SEL_IR : CAP_DR;
                CAP_DR: tap <= bus.TMS ? EX1_DR : SH_DR;
                SH_DR:  tap <= bus.TMS ? EX1_DR : SH_DR;
                EX1_DR: tap <= bus.TMS ? UPD_DR : PAU_DR;
                PAU_DR: tap <= bus.TMS ? EX2_DR : PAU_DR;
                EX2_DR: tap <= bus.TMS ? UPD_DR : SH_DR;
                UPD_DR: tap <= bus.TMS ? SEL_DR : RTI;
                SEL_IR: tap <= bus.TMS ? TLR    : CAP_IR;
                CAP_IR: tap <= bus.TMS ? EX1_IR : SH_IR;
                SH_IR:  tap <= bus.TMS ? EX1_IR : SH_IR;
                EX1_IR: tap <= bus.TMS ? UPD_IR : PAU_IR;
                PAU_IR: tap <= bus.TMS ? EX2_IR : PAU_IR;
                EX2_IR: tap <= bus.TMS ? UPD_IR : SH_IR;
                default: tap <= bus.TMS ? SEL_DR : RTI;
            endcase
        end
    end

    // Boundary register loop-back: TDO presents bit 0, TDI enters at the top
    always @(posedge TCK) begin
        if (tap == SH_DR) bsr <= {bus.TDI, bsr[13:1]};
    end
    assign bus.TDO = bsr[0];

    int checks   = 0;
    int failures = 0;

    a_shift_window: assert property (@(negedge TCK) disable iff (RST)
        bus.shift_dr == (tap == SH_DR))
    else begin
        failures++;
        $display("FAIL shift_window: shift_dr=%0b tap_state=%0d", bus.shift_dr, tap);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {tms, tdi, shift_dr, strobe, busy, done}
    typedef logic [5:0] step_t;
    step_t exp_seq [30];

    task automatic build_seq(input logic [3:0] ins, input logic [13:0] pat, input logic ce);
        logic [3:0] irsel;
        logic [2:0] drsel;
        int k;
        irsel = 4'b0011;
        drsel = 3'b001;
        k = 0;
        for (int s = 0; s < 4; s++)  begin exp_seq[k] = {irsel[s], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; k++; end
        for (int i = 0; i < 4; i++)  begin exp_seq[k] = {(i == 3), ins[i], 1'b0, 1'b0, 1'b1, 1'b0}; k++; end
        exp_seq[k] = 6'b100010; k++;
        exp_seq[k] = 6'b000010; k++;
        for (int s = 0; s < 3; s++)  begin exp_seq[k] = {drsel[s], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; k++; end
        for (int i = 0; i < 14; i++) begin exp_seq[k] = {(i == 13), pat[i], 1'b1, ce, 1'b1, 1'b0}; k++; end
        exp_seq[k] = 6'b100010; k++;
        exp_seq[k] = 6'b000010; k++;
        exp_seq[k] = 6'b000001;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(posedge TCK); #1;
            n++;
        end
        check($sformatf("%s_idle", tag), {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_scan(input logic [3:0] ins, input logic [13:0] pat, input logic ce,
                            input logic [13:0] exp_tdo, input string tag);
        wait_idle(tag);
        build_seq(ins, pat, ce);
        @(negedge TCK);
        bus.start = 1'b1; bus.instr = ins; bus.pattern = pat; bus.cmp_en = ce;
        @(posedge TCK); #1;
        // Scramble inputs so any missing latch shows up in the stream
        bus.start = 1'b0; bus.instr = ~ins; bus.pattern = ~pat; bus.cmp_en = ~ce;
        check($sformatf("%s_tdo_clear", tag), {18'd0, bus.tdo_data}, 32'd0);
        for (int k = 0; k < 30; k++) begin
            if (k != 0) begin @(posedge TCK); #1; end
            check($sformatf("%s_step%0d", tag, k),
                  {26'd0, bus.TMS, bus.TDI, bus.shift_dr, bus.strobe, bus.busy, bus.done},
                  {26'd0, exp_seq[k]});
        end
        check($sformatf("%s_tdo_data", tag), {18'd0, bus.tdo_data}, {18'd0, exp_tdo});
    endtask

    task automatic check_reset_values(input string tag);
        check($sformatf("%s_rstval", tag),
              {24'd0, bus.TMS, bus.TDI, bus.shift_dr, bus.strobe, bus.busy, bus.done, 2'b00},
              {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
        check($sformatf("%s_rst_tdo", tag), {18'd0, bus.tdo_data}, 32'd0);
    endtask

    // TMS=1 on five edges after release, one TMS=0, then busy drops
    task automatic check_release(input string tag);
        for (int k = 1; k <= 7; k++) begin
            @(posedge TCK); #1;
            check($sformatf("%s_rel%0d", tag, k),
                  {28'd0, bus.TMS, bus.TDI, bus.busy, bus.done},
                  {28'd0, (k <= 5), 1'b0, (k <= 6), 1'b0});
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 60) begin
            @(posedge TCK); #1;
            cyc++;
        end
    endtask

    typedef struct {
        logic [3:0]  instr;
        logic [13:0] pattern;
        logic        cmp_en;
        logic [13:0] exp_tdo;
    } scan_vec_t;

    scan_vec_t vecs [4];

    initial begin
        int          cyc;
        logic [13:0] snap;

        vecs[0] = '{instr: c_sample, pattern: 14'h2A5C, cmp_en: 1'b1, exp_tdo: 14'h3001};
        vecs[1] = '{instr: c_bypass, pattern: 14'h1555, cmp_en: 1'b1, exp_tdo: 14'h2A5C};
        vecs[2] = '{instr: c_extest, pattern: 14'h3FFF, cmp_en: 1'b0, exp_tdo: 14'h1555};
        vecs[3] = '{instr: 4'b1011,  pattern: 14'h0001, cmp_en: 1'b1, exp_tdo: 14'h3FFF};

        bus.start = 1'b0; bus.cmp_en = 1'b0; bus.instr = '0; bus.pattern = '0;

        #1 RST = 1'b1;
        #1 check_reset_values("por");
        @(negedge TCK);
        RST = 1'b0;
        check_release("por");

        for (int v = 0; v < 4; v++) begin
            run_scan(vecs[v].instr, vecs[v].pattern, vecs[v].cmp_en, vecs[v].exp_tdo,
                     $sformatf("vec%0d", v));
        end

        // Start held through the whole scan, then re-raised the cycle after done
        wait_idle("hold");
        @(negedge TCK);
        bus.start = 1'b1; bus.instr = c_sample; bus.pattern = 14'h0ABC; bus.cmp_en = 1'b1;
        @(posedge TCK); #1;
        check("hold_accept", {31'd0, bus.busy}, 32'd1);
        wait_done(cyc);
        bus.start = 1'b0;
        check("hold_done_cycle", cyc, 29);
        check("hold_done_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge TCK); #1;
        check("hold_single", {30'd0, bus.busy, bus.done}, 32'd0);
        bus.start = 1'b1; bus.pattern = 14'h1234;
        @(posedge TCK); #1;
        bus.start = 1'b0;
        check("after_done_accept", {31'd0, bus.busy}, 32'd1);
        wait_done(cyc);
        check("after_done_cycle", cyc, 29);

        // Reset in the middle of DR shift bit 7
        wait_idle("midrst");
        @(negedge TCK);
        bus.start = 1'b1; bus.instr = c_sample; bus.pattern = 14'h2AAA; bus.cmp_en = 1'b1;
        @(posedge TCK); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge TCK); #1;
            if (bus.done !== 1'b0) check("midrst_no_done", {31'd0, bus.done}, 32'd0);
        end
        check("midrst_window", {31'd0, bus.shift_dr}, 32'd1);
        RST = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge TCK);
        RST = 1'b0;
        check_release("midrst");

        wait_idle("post");
        snap = bsr;
        run_scan(c_bypass, 14'h0F0F, 1'b1, snap, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
